// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the d-cache port arbiter: FSM states, grant decision and address masking.
// Pure declarations; no timing or flow control lives here.
package dcache_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_LD_BUSY,
        ARB_ST_BUSY,
        ARB_DRAIN,
        ARB_GAP
    } dport_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LD,
        GNT_ST
    } grant_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [3:0]  BE_ALL    = 4'hF;

endpackage

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single d-cache port between load and store queue heads; strobe 1 cycle after grant.
// Requests are held by the queues until done; one idle GAP cycle follows every response.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int MAX_LD_STREAK = 4,
    parameter int CNT_W         = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_ld_req,
    input  logic [31:0] i_ld_addr,
    input  logic        i_st_req,
    input  logic [31:0] i_st_addr,
    input  logic [31:0] i_st_wdata,
    input  logic [3:0]  i_st_be,
    output logic        o_ld_done,
    output logic [31:0] o_ld_rdata,
    output logic        o_st_done,
    output logic        o_flush_busy,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_byte_enable,
    input  logic        i_mem_resp,
    input  logic [31:0] i_mem_rdata
);

    dport_state_t     r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_streak, w_streak_nxt;
    logic [31:0]      r_addr,   w_addr_nxt;
    logic [31:0]      r_wdata,  w_wdata_nxt;
    logic [3:0]       r_be,     w_be_nxt;
    logic             r_is_st,  w_is_st_nxt;
    logic             w_ld_done;
    logic             w_st_done;
    logic             w_streak_full;
    grant_t           w_grant;

    // A same-word hazard always lets the store go first so the load observes its data.
    function automatic grant_t pick_grant(
        input logic        ld,
        input logic        st,
        input logic [31:0] la,
        input logic [31:0] sa,
        input logic        full
    );
        logic hazard;
        hazard = ld & st & (((la ^ sa) & WORD_MASK) == 32'h0);
        if (st && (!ld || hazard || full)) return GNT_ST;
        if (ld) return GNT_LD;
        return GNT_NONE;
    endfunction

    assign w_streak_full = (r_streak == CNT_W'(MAX_LD_STREAK));
    assign w_grant       = pick_grant(i_ld_req, i_st_req, i_ld_addr, i_st_addr, w_streak_full);

    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_be_nxt     = r_be;
        w_is_st_nxt  = r_is_st;
        w_ld_done    = 1'b0;
        w_st_done    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (i_flush) begin
                    w_streak_nxt = '0;
                end else if (w_grant == GNT_LD) begin
                    w_state_nxt = ARB_LD_BUSY;
                    w_addr_nxt  = i_ld_addr & WORD_MASK;
                    w_be_nxt    = BE_ALL;
                    w_is_st_nxt = 1'b0;
                    if (!i_st_req)          w_streak_nxt = '0;
                    else if (!w_streak_full) w_streak_nxt = r_streak + CNT_W'(1);
                end else if (w_grant == GNT_ST) begin
                    w_state_nxt  = ARB_ST_BUSY;
                    w_addr_nxt   = i_st_addr & WORD_MASK;
                    w_wdata_nxt  = i_st_wdata;
                    w_be_nxt     = i_st_be;
                    w_is_st_nxt  = 1'b1;
                    w_streak_nxt = '0;
                end
            end
            ARB_LD_BUSY, ARB_ST_BUSY: begin
                if (i_mem_resp) begin
                    w_state_nxt = ARB_GAP;
                    w_ld_done   = (r_state == ARB_LD_BUSY) & ~i_flush & ~i_rst;
                    w_st_done   = (r_state == ARB_ST_BUSY) & ~i_flush & ~i_rst;
                end else if (i_flush) begin
                    w_state_nxt = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (i_mem_resp) w_state_nxt = ARB_GAP;
            end
            ARB_GAP: begin
                w_state_nxt = ARB_IDLE;
                if (i_flush) w_streak_nxt = '0;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ARB_IDLE;
            r_streak <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_is_st  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_be     <= w_be_nxt;
            r_is_st  <= w_is_st_nxt;
        end
    end

    // DRAIN keeps presenting the flushed access until the cache answers it.
    assign o_mem_read        = (r_state == ARB_LD_BUSY) | ((r_state == ARB_DRAIN) & ~r_is_st);
    assign o_mem_write       = (r_state == ARB_ST_BUSY) | ((r_state == ARB_DRAIN) &  r_is_st);
    assign o_mem_address     = r_addr;
    assign o_mem_wdata       = r_wdata;
    assign o_mem_byte_enable = r_be;
    assign o_flush_busy      = (r_state == ARB_DRAIN);
    assign o_ld_done         = w_ld_done;
    assign o_st_done         = w_st_done;
    assign o_ld_rdata        = w_ld_done ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized and directed bench for dcache_port_arbiter against a transaction-level port model.
module tb_dcache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush, ld_req, st_req, mem_resp;
    logic [31:0] ld_addr, st_addr, st_wdata, mem_rdata;
    logic [3:0]  st_be;
    logic        ld_done, st_done, flush_busy, mem_read, mem_write;
    logic [31:0] ld_rdata, mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;

    always #5 clk = ~clk;

    dcache_port_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_ld_req(ld_req), .i_ld_addr(ld_addr),
        .i_st_req(st_req), .i_st_addr(st_addr), .i_st_wdata(st_wdata), .i_st_be(st_be),
        .o_ld_done(ld_done), .o_ld_rdata(ld_rdata), .o_st_done(st_done),
        .o_flush_busy(flush_busy), .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_mem_address(mem_address), .o_mem_wdata(mem_wdata),
        .o_mem_byte_enable(mem_byte_enable),
        .i_mem_resp(mem_resp), .i_mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } st_t;

    logic [31:0] ldq[$];
    st_t         stq[$];

    int n_chk = 0, n_bad = 0, cyc = 0;

    // Port model: which access owns the port (0 none, 1 load, 2 store), whether it is
    // being discarded, whether a bubble is owed, and how many loads passed a waiting store.
    int          m_kind = 0, m_run = 0;
    bit          m_flushed = 0, m_gap = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_be = 0;

    // Environment knobs
    int lat_min = 1, lat_max = 1, flush_rate = 0, stray_rate = 0;
    int flush_after_rise = -1, rst_after_rise = -1, rst_cycles = 0;
    bit flush_on_st_resp = 0, kill_ld = 0, fill_en = 0, fix_en = 0;
    logic [31:0] fix_rdata = 0;
    int wait_cnt = 0, age = 0;
    bit strobe_prev = 0, dut_prev = 0;

    // Observation logs
    logic [31:0] grant_code, last_rise_addr, last_ld_rdata;
    logic [3:0]  last_rise_be;
    int n_ld_done, n_st_done, fb_cycles, strobe_cycles, rise_cyc, done_cyc;
    int flush_cyc, flush_to_rise;
    bit flush_armed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input string s);
        logic [31:0] v = 0;
        for (int i = 0; i < s.len(); i++) v = (v << 2) | ((s[i] == "L") ? 32'd1 : 32'd2);
        return v;
    endfunction

    task automatic clear_logs();
        grant_code = 0; last_rise_addr = 0; last_rise_be = 0; last_ld_rdata = 0;
        n_ld_done = 0; n_st_done = 0; fb_cycles = 0; strobe_cycles = 0;
        rise_cyc = 0; done_cyc = 0; flush_cyc = 0; flush_to_rise = -1; flush_armed = 0;
    endtask

    task automatic step();
        bit es, same, e_ldd, e_std, dstb;
        @(negedge clk);
        cyc++;
        es = (m_kind != 0);
        if (es) begin
            if (!strobe_prev) begin
                age = 0;
                wait_cnt = $urandom_range(lat_max, lat_min);
            end else age++;
        end
        rst = (rst_cycles > 0);
        if (rst_cycles > 0) rst_cycles--;
        if (es && age == rst_after_rise) begin rst = 1; rst_after_rise = -1; end
        ld_req   = (ldq.size() != 0);
        ld_addr  = ld_req ? ldq[0] : $urandom();
        st_req   = (stq.size() != 0);
        st_addr  = st_req ? stq[0].a : $urandom();
        st_wdata = st_req ? stq[0].d : $urandom();
        st_be    = st_req ? stq[0].be : 4'($urandom());
        mem_resp = 0;
        if (es) begin
            if (wait_cnt == 0) mem_resp = 1; else wait_cnt--;
        end else if (stray_rate != 0 && $urandom_range(stray_rate - 1, 0) == 0) mem_resp = 1;
        mem_rdata = mem_resp ? (fix_en ? fix_rdata : $urandom()) : 32'h0;
        flush = (flush_rate != 0 && $urandom_range(flush_rate - 1, 0) == 0);
        if (es && age == flush_after_rise) begin flush = 1; flush_after_rise = -1; end
        if (flush_on_st_resp && mem_resp && m_kind == 2) begin flush = 1; flush_on_st_resp = 0; end
        #1;
        e_ldd = (m_kind == 1) && !m_flushed && mem_resp && !flush && !rst;
        e_std = (m_kind == 2) && !m_flushed && mem_resp && !flush && !rst;
        chk("mem_read",   32'(mem_read),        32'(m_kind == 1));
        chk("mem_write",  32'(mem_write),       32'(m_kind == 2));
        chk("mem_addr",   mem_address,          m_addr);
        chk("mem_wdata",  mem_wdata,            m_wdata);
        chk("mem_be",     32'(mem_byte_enable), 32'(m_be));
        chk("flush_busy", 32'(flush_busy),      32'(m_kind != 0 && m_flushed));
        chk("ld_done",    32'(ld_done),         32'(e_ldd));
        chk("st_done",    32'(st_done),         32'(e_std));
        chk("ld_rdata",   ld_rdata,             e_ldd ? mem_rdata : 32'h0);
        // DUT-side logs for the directed scenario checks
        dstb = mem_read | mem_write;
        if (dstb) strobe_cycles++;
        if (flush_busy) fb_cycles++;
        if (dstb && !dut_prev) begin
            grant_code = (grant_code << 2) | (mem_read ? 32'd1 : 32'd2);
            last_rise_addr = mem_address;
            last_rise_be = mem_byte_enable;
            rise_cyc = cyc;
            if (flush_armed) begin flush_to_rise = cyc - flush_cyc; flush_armed = 0; end
        end
        dut_prev = dstb;
        if (ld_done) begin n_ld_done++; last_ld_rdata = ld_rdata; done_cyc = cyc; end
        if (st_done) n_st_done++;
        if (flush) begin flush_cyc = cyc; flush_armed = 1; end
        // Environment: queues retire on completion; flush/reset kill pending loads
        if (e_ldd) void'(ldq.pop_front());
        if (e_std) void'(stq.pop_front());
        if (flush && kill_ld) ldq.delete();
        if (rst) begin ldq.delete(); stq.delete(); end
        // Model advance
        if (rst) begin
            m_kind = 0; m_flushed = 0; m_gap = 0; m_run = 0;
            m_addr = 0; m_wdata = 0; m_be = 0;
        end else if (m_kind != 0) begin
            if (mem_resp) begin m_kind = 0; m_flushed = 0; m_gap = 1; end
            else if (flush) m_flushed = 1;
        end else if (m_gap) begin
            m_gap = 0;
            if (flush) m_run = 0;
        end else if (flush) begin
            m_run = 0;
        end else begin
            same = ld_req && st_req && ((ld_addr >> 2) == (st_addr >> 2));
            if (st_req && (!ld_req || same || m_run == 4)) begin
                m_kind = 2; m_addr = st_addr & ~32'h3; m_wdata = st_wdata; m_be = st_be; m_run = 0;
            end else if (ld_req) begin
                m_kind = 1; m_addr = ld_addr & ~32'h3; m_be = 4'hF;
                m_run = st_req ? ((m_run < 4) ? m_run + 1 : 4) : 0;
            end
        end
        strobe_prev = es;
        if (fill_en) begin
            st_t s;
            if (ldq.size() == 0 && $urandom_range(2, 0) == 0)
                ldq.push_back(32'h9000 + $urandom_range(31, 0));
            if (stq.size() == 0 && $urandom_range(3, 0) == 0) begin
                s.a = 32'h9000 + $urandom_range(31, 0);
                s.d = $urandom();
                s.be = 4'($urandom_range(15, 1));
                stq.push_back(s);
            end
        end
    endtask

    task automatic do_reset();
        rst_cycles = 1;
        step();
        step();
        clear_logs();
    endtask

    task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_t s;
        s.a = a; s.d = d; s.be = be;
        stq.push_back(s);
    endtask

    initial begin
        int n;
        rst = 1; flush = 0; ld_req = 0; st_req = 0; mem_resp = 0;
        ld_addr = 0; st_addr = 0; st_wdata = 0; st_be = 0; mem_rdata = 0;
        clear_logs();
        do_reset();

        // Load only
        lat_min = 2; lat_max = 2; fix_en = 1; fix_rdata = 32'hA5A5_A5A5;
        ldq.push_back(32'h1006);
        repeat (8) step();
        chk("t1_order",   grant_code, enc("L"));
        chk("t1_addr",    last_rise_addr, 32'h1004);
        chk("t1_be",      32'(last_rise_be), 32'hF);
        chk("t1_ndone",   n_ld_done, 1);
        chk("t1_rdata",   last_ld_rdata, 32'hA5A5_A5A5);
        chk("t1_latency", done_cyc - rise_cyc, 2);
        chk("t1_strobes", strobe_cycles, 3);
        fix_en = 0;

        // Same-word hazard: store first
        do_reset();
        ldq.push_back(32'h2000);
        push_st(32'h2002, 32'h00AB_0000, 4'b0100);
        repeat (12) step();
        chk("t2_order",  grant_code, enc("SL"));
        chk("t2_ldone",  n_ld_done, 1);
        chk("t2_sdone",  n_st_done, 1);

        // Starvation limit
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) ldq.push_back(32'h3000 + 32'(i * 4));
        push_st(32'h4000, 32'h1111_1111, 4'hF);
        push_st(32'h4004, 32'h2222_2222, 4'h3);
        n = 0;
        while ((ldq.size() != 0 || stq.size() != 0) && n < 200) begin step(); n++; end
        chk("t3_timeout", 32'(n < 200), 1);
        chk("t3_order",   grant_code, enc("LLLLSLLLLSLL"));
        chk("t3_ldone",   n_ld_done, 10);
        chk("t3_sdone",   n_st_done, 2);

        // Flush mid-load
        do_reset();
        kill_ld = 1; lat_min = 5; lat_max = 5; flush_after_rise = 2;
        ldq.push_back(32'h5008);
        repeat (15) step();
        chk("t4_order",   grant_code, enc("L"));
        chk("t4_ldone",   n_ld_done, 0);
        chk("t4_drain",   fb_cycles, 3);
        chk("t4_strobes", strobe_cycles, 6);

        // Flush coincident with store response, load pending
        do_reset();
        kill_ld = 0; lat_min = 2; lat_max = 2;
        push_st(32'h6000, 32'hCAFE_F00D, 4'hF);
        step();
        ldq.push_back(32'h7000);
        flush_on_st_resp = 1;
        repeat (20) step();
        chk("t5_order",  grant_code, enc("SLS"));
        chk("t5_gap",    flush_to_rise, 3);
        chk("t5_drain",  fb_cycles, 0);
        chk("t5_ldone",  n_ld_done, 1);
        chk("t5_sdone",  n_st_done, 1);

        // Reset during a load, then stray responses
        do_reset();
        lat_min = 6; lat_max = 6; rst_after_rise = 1;
        ldq.push_back(32'h8000);
        step();
        stray_rate = 2;
        repeat (14) step();
        stray_rate = 0;
        chk("t6_order",   grant_code, enc("L"));
        chk("t6_ldone",   n_ld_done, 0);
        chk("t6_strobes", strobe_cycles, 2);

        // Random traffic
        do_reset();
        lat_min = 0; lat_max = 3; flush_rate = 15; stray_rate = 10; kill_ld = 1; fill_en = 1;
        repeat (3000) step();
        flush_rate = 0; fill_en = 0;
        n = 0;
        while ((ldq.size() != 0 || stq.size() != 0 || m_kind != 0 || m_gap) && n < 500) begin
            step();
            n++;
        end
        chk("rand_drain", 32'(n < 500), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
